// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide,
// one bit per clock over WIDTH cycles, with MTHI/MTLO write port.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, CALC} stateT;

   stateT              state;
   logic               isDiv;
   logic               prodSign;
   logic               quotSign;
   logic               remSign;
   logic [WIDTH-1:0]   aMag;
   logic [WIDTH-1:0]   bMag;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quot;
   logic [CW-1:0]      count;

   logic               isSigned;
   logic               signA;
   logic               signB;
   logic [WIDTH-1:0]   aIn;
   logic [WIDTH-1:0]   bIn;
   logic [WIDTH:0]     mulSum;
   logic [2*WIDTH-1:0] accNext;
   logic [WIDTH:0]     remShift;
   logic [WIDTH:0]     remDiff;
   logic [WIDTH-1:0]   remNext;
   logic [WIDTH-1:0]   quotNext;
   logic [2*WIDTH-1:0] prodFinal;
   logic [WIDTH-1:0]   quotFinal;
   logic [WIDTH-1:0]   remFinal;
   logic               lastStep;

   always_comb begin
      isSigned = ~op[0];
      signA    = isSigned & rs_data[WIDTH-1];
      signB    = isSigned & rt_data[WIDTH-1];
      aIn      = signA ? -rs_data : rs_data;
      bIn      = signB ? -rt_data : rt_data;

      // Multiply: add multiplicand into the upper half when the current LSB is set, then shift right.
      mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, aMag} : '0);
      accNext  = {mulSum, acc[WIDTH-1:1]};

      // Divide: a negative trial difference means restore, so the shifted value is kept.
      remShift = {rem, quot[WIDTH-1]};
      remDiff  = remShift - {1'b0, bMag};
      if (remDiff[WIDTH]) begin
         remNext  = remShift[WIDTH-1:0];
         quotNext = {quot[WIDTH-2:0], 1'b0};
      end else begin
         remNext  = remDiff[WIDTH-1:0];
         quotNext = {quot[WIDTH-2:0], 1'b1};
      end

      prodFinal = prodSign ? -accNext : accNext;
      quotFinal = quotSign ? -quotNext : quotNext;
      remFinal  = remSign ? -remNext : remNext;
      lastStep  = (count == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         isDiv    <= 1'b0;
         prodSign <= 1'b0;
         quotSign <= 1'b0;
         remSign  <= 1'b0;
         aMag     <= '0;
         bMag     <= '0;
         acc      <= '0;
         rem      <= '0;
         quot     <= '0;
         count    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= CALC;
                  isDiv    <= op[1];
                  prodSign <= signA ^ signB;
                  quotSign <= signA ^ signB;
                  remSign  <= signA;
                  aMag     <= aIn;
                  bMag     <= bIn;
                  acc      <= {{WIDTH{1'b0}}, bIn};
                  rem      <= '0;
                  quot     <= aIn;
                  count    <= '0;
                  busy     <= 1'b1;
               end else begin
                  if (hi_we) hi <= wdata;
                  if (lo_we) lo <= wdata;
               end
            end
            CALC: begin
               acc   <= accNext;
               rem   <= remNext;
               quot  <= quotNext;
               count <= count + CW'(1);
               if (lastStep) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  if (isDiv) begin
                     hi <= remFinal;
                     lo <= quotFinal;
                  end else begin
                     hi <= prodFinal[2*WIDTH-1:WIDTH];
                     lo <= prodFinal[WIDTH-1:0];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against an arithmetic
// reference model of HI/LO results.
module tb_mult_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] rs_data = '0;
   logic [W-1:0] rt_data = '0;
   logic         hi_we = 1'b0;
   logic         lo_we = 1'b0;
   logic [W-1:0] wdata = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int unsigned  nVec = 0;
   int unsigned  nMis = 0;
   logic [W-1:0] expHi = '0;
   logic [W-1:0] expLo = '0;

   typedef struct {
      logic [1:0]   o;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] h;
      logic [W-1:0] l;
   } vecT;

   vecT dirVecs[8] = '{
      '{2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB},
      '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001},
      '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD},
      '{2'd3, 32'd100,       32'd7,         32'd2,         32'd14},
      '{2'd3, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF},
      '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000},
      '{2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'h0000_0001},
      '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000}
   };

   mult_div_unit #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .hi_we   (hi_we),
      .lo_we   (lo_we),
      .wdata   (wdata),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      nVec++;
      if (got !== exp) begin
         nMis++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Returns {hi, lo} from plain integer arithmetic.
   function automatic logic [2*W-1:0] refModel(input logic [1:0] o, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
      longint       sa;
      longint       sb;
      longint       q;
      longint       r;
      logic [2*W-1:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         2'd0: res = 64'(sa * sb);
         2'd1: res = {{W{1'b0}}, a} * {{W{1'b0}}, b};
         2'd2: begin
            if (b == '0) begin
               res = {a, (a[W-1] ? 32'd1 : {W{1'b1}})};
            end else begin
               q   = sa / sb;
               r   = sa % sb;
               res = {r[W-1:0], q[W-1:0]};
            end
         end
         default: begin
            if (b == '0) res = {a, {W{1'b1}}};
            else         res = {a % b, a / b};
         end
      endcase
      return res;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom % 6)
         0:       return '0;
         1:       return 32'd1;
         2:       return 32'h8000_0000;
         3:       return '1;
         default: return W'($urandom);
      endcase
   endfunction

   // Caller is at a negedge with the DUT idle; returns one negedge after the accept edge.
   task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit withStrobe);
      start   = 1'b1;
      op      = o;
      rs_data = a;
      rt_data = b;
      if (withStrobe) begin
         hi_we = 1'b1;
         lo_we = 1'b1;
         wdata = W'($urandom);
      end
      @(negedge clk);
      start   = 1'b0;
      hi_we   = 1'b0;
      lo_we   = 1'b0;
      rs_data = W'($urandom);
      rt_data = W'($urandom);
      checkVal("busyAfterIssue", W'(busy), W'(1));
      checkVal("doneLowAfterIssue", W'(done), W'(0));
      checkVal("hiHeldDuringCalc", hi, expHi);
      checkVal("loHeldDuringCalc", lo, expLo);
      {expHi, expLo} = refModel(o, a, b);
   endtask

   // Returns at the negedge after completion, with done expected high.
   task automatic waitDone(input bit inject);
      int cnt;
      cnt = 0;
      while (busy && cnt < 200) begin
         cnt++;
         if (inject && cnt == 10) begin
            start   = 1'b1;
            op      = 2'd1;
            rs_data = 32'd1000;
            rt_data = 32'd1000;
            hi_we   = 1'b1;
            wdata   = 32'hDEAD_BEEF;
         end else begin
            start = 1'b0;
            hi_we = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      hi_we = 1'b0;
      checkVal("busyCycles", W'(cnt), W'(W));
      checkVal("donePulse", W'(done), W'(1));
      checkVal("hiResult", hi, expHi);
      checkVal("loResult", lo, expLo);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]   o;
      logic [W-1:0] a;
      logic [W-1:0] b;
      bit           hw;
      bit           lw;

      @(negedge clk);
      checkVal("resetBusy", W'(busy), W'(0));
      checkVal("resetDone", W'(done), W'(0));
      checkVal("resetHi", hi, '0);
      checkVal("resetLo", lo, '0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (dirVecs[i]) begin
         issue(dirVecs[i].o, dirVecs[i].a, dirVecs[i].b, 1'b0);
         waitDone(1'b0);
         checkVal("dirHi", hi, dirVecs[i].h);
         checkVal("dirLo", lo, dirVecs[i].l);
         @(negedge clk);
         checkVal("doneOneCycle", W'(done), W'(0));
      end

      // Start and MTHI while busy are both ignored.
      issue(2'd1, 32'd5, 32'd6, 1'b0);
      waitDone(1'b1);
      checkVal("ignoredStartHi", hi, 32'd0);
      checkVal("ignoredStartLo", lo, 32'd30);
      @(negedge clk);
      checkVal("noRequeue", W'(busy), W'(0));

      lo_we = 1'b1;
      wdata = 32'hCAFE_BABE;
      @(negedge clk);
      lo_we = 1'b0;
      expLo = 32'hCAFE_BABE;
      checkVal("mtloLo", lo, 32'hCAFE_BABE);
      checkVal("mtloHiHeld", hi, expHi);

      // Strobes coinciding with start are dropped (hiHeld/loHeld checks inside issue).
      issue(2'd3, 32'd77, 32'd5, 1'b1);
      waitDone(1'b0);

      // Back-to-back issue in the done cycle, then randomized traffic.
      for (int i = 0; i < 60; i++) begin
         o = 2'($urandom_range(0, 3));
         a = pick();
         b = pick();
         if ($urandom % 2 == 0) begin
            repeat ($urandom_range(1, 2)) begin
               hw    = 1'($urandom % 2);
               lw    = 1'($urandom % 2);
               hi_we = hw;
               lo_we = lw;
               wdata = W'($urandom);
               @(negedge clk);
               if (hw) expHi = wdata;
               if (lw) expLo = wdata;
               hi_we = 1'b0;
               lo_we = 1'b0;
               checkVal("mtRandHi", hi, expHi);
               checkVal("mtRandLo", lo, expLo);
            end
         end
         issue(o, a, b, 1'($urandom % 2));
         waitDone(1'b0);
      end

      // Asynchronous reset mid-divide aborts without a HI/LO update.
      @(negedge clk);
      issue(2'd3, 32'hFFFF_0000, 32'd3, 1'b0);
      repeat (14) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkVal("abortBusy", W'(busy), W'(0));
      checkVal("abortDone", W'(done), W'(0));
      checkVal("abortHi", hi, '0);
      checkVal("abortLo", lo, '0);
      expHi = '0;
      expLo = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(2'd0, 32'd2, 32'd3, 1'b0);
      waitDone(1'b0);
      checkVal("postResetLo", lo, 32'd6);
      checkVal("postResetHi", hi, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
